// File: rtl/ahb5_random_wait_subordinate.sv
// AHB5 word-addressed SRAM subordinate with LFSR-driven random wait states and two-cycle ERROR responses.
// Optional: define AHB5_SUB_PROT_CHECK_EN to reject unprivileged accesses to the upper half of memory.
module ahb5_random_wait_subordinate #(
    parameter int          MEM_DEPTH_WORDS = 256,
    parameter int          MAX_WAIT        = 3,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);
    localparam int AW = $clog2(MEM_DEPTH_WORDS);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [15:0]   lfsr, lfsr_nxt;
    logic [31:0]   mem [MEM_DEPTH_WORDS];
    logic [AW-1:0] dp_word, rd_word;
    logic [1:0]    dp_ofs, dp_size;
    logic          dp_write;
    logic [31:0]   rdata_q, rdata_nxt, merged;
    logic [3:0]    be, wait_draw;
    logic          free, accept, acc_err, commit, nxt_is_read;
    logic          unused_ok;

    assign unused_ok = ^{HBURST, HPROT};

    // Galois form of x^16+x^14+x^13+x^11+1
    assign lfsr_nxt  = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ 16'hB400) : {1'b0, lfsr[15:1]};
    assign wait_draw = 4'(32'(lfsr[3:0]) % (MAX_WAIT + 1));

    // A new address phase can only land while we are not stalling the bus
    assign free   = (state == S_IDLE) || (state == S_LAST) || (state == S_ERR2);
    assign accept = free && HSEL && HREADY && HTRANS[1];
    assign commit = (state == S_LAST) && dp_write;

    always_comb begin
        acc_err = 1'b0;
        if (HSIZE > 3'd2)                                    acc_err = 1'b1;
        if (HSIZE == 3'd1 && HADDR[0])                       acc_err = 1'b1;
        if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)            acc_err = 1'b1;
        if ({2'b00, HADDR[31:2]} >= 32'(MEM_DEPTH_WORDS))    acc_err = 1'b1;
`ifdef AHB5_SUB_PROT_CHECK_EN
        if (!HPROT[1] && ({2'b00, HADDR[31:2]} >= 32'(MEM_DEPTH_WORDS / 2)))
            acc_err = 1'b1;
`endif
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nxt = S_LAST;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_ERR1: state_nxt = S_ERR2;
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
                if (accept) begin
                    if (acc_err) begin
                        state_nxt = S_ERR1;
                    end else if (wait_draw != 4'd0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = wait_draw;
                    end else begin
                        state_nxt = S_LAST;
                    end
                end
            end
        endcase
    end

    // Write lane merge for the data phase closing this cycle
    always_comb begin
        be = 4'b0000;
        case (dp_size)
            2'd0:    be = 4'b0001 << dp_ofs;
            2'd1:    be = dp_ofs[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        merged = mem[dp_word];
        for (int b = 0; b < 4; b++)
            if (be[b]) merged[8*b +: 8] = HWDATA[8*b +: 8];
    end

    // Read data is registered on entry to LAST; a same-edge write is forwarded
    always_comb begin
        rd_word     = accept ? HADDR[AW+1:2] : dp_word;
        nxt_is_read = accept ? !HWRITE : !dp_write;
        rdata_nxt   = '0;
        if (state_nxt == S_LAST && nxt_is_read)
            rdata_nxt = (commit && rd_word == dp_word) ? merged : mem[rd_word];
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            lfsr     <= LFSR_SEED;
            rdata_q  <= '0;
            dp_word  <= '0;
            dp_ofs   <= 2'b00;
            dp_size  <= 2'b00;
            dp_write <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            lfsr    <= lfsr_nxt;
            rdata_q <= rdata_nxt;
            if (accept) begin
                dp_word  <= HADDR[AW+1:2];
                dp_ofs   <= HADDR[1:0];
                dp_size  <= HSIZE[1:0];
                dp_write <= HWRITE && !acc_err;
            end
        end
    end

    // Reset forces state to IDLE asynchronously, so a pending write cannot commit
    always_ff @(posedge HCLK) begin
        if (commit) mem[dp_word] <= merged;
    end

    assign HREADYOUT = !((state == S_WAIT) || (state == S_ERR1));
    assign HRESP     = (state == S_ERR1) || (state == S_ERR2);
    assign HRDATA    = rdata_q;

endmodule

// File: tb/tb_ahb5_random_wait_subordinate.sv
// Randomized bench for ahb5_random_wait_subordinate: transaction-level scoreboard plus wait-state prediction.
module tb_ahb5_random_wait_subordinate;
    localparam int          DEPTH    = 256;
    localparam int          MAX_WAIT = 3;
    localparam logic [15:0] SEED     = 16'hACE1;
`ifdef AHB5_SUB_PROT_CHECK_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] mdl_lfsr;
    logic [31:0] sb [0:DEPTH-1];

    assign HREADY = HREADYOUT;

    ahb5_random_wait_subordinate #(
        .MEM_DEPTH_WORDS(DEPTH), .MAX_WAIT(MAX_WAIT), .LFSR_SEED(SEED)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    always @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) mdl_lfsr <= SEED;
        else          mdl_lfsr <= lfsr_step(mdl_lfsr);

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] s, input logic [3:0] p);
        bit e;
        e = (s > 3'd2) || ((a % (32'd1 << s)) != 0) || ((a / 4) >= DEPTH);
        if (PROT_EN && !p[1] && (a / 4) >= DEPTH / 2) e = 1'b1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        repeat (n) @(negedge HCLK);
    endtask

    // Called at a negedge where the bus is ready; returns at the negedge of the
    // closing data-phase cycle, so back-to-back calls pipeline naturally.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [3:0] prot, input string tag);
        bit          err;
        int          w, lows, idx, ofs;
        logic [31:0] exp_rd;
        err    = is_err(a, sz, prot);
        w      = int'(mdl_lfsr[3:0]) % (MAX_WAIT + 1);
        idx    = int'(a >> 2);
        ofs    = int'(a[1:0]);
        exp_rd = '0;
        if (!err && !wr) exp_rd = sb[idx];
        if (!err && wr)
            for (int b = 0; b < 4; b++)
                if (b >= ofs && b < ofs + (1 << sz)) sb[idx][8*b +: 8] = wd[8*b +: 8];
        HSEL = 1'b1; HADDR = a; HTRANS = 2'b10; HWRITE = wr;
        HSIZE = sz; HPROT = prot; HBURST = 3'b000;
        @(posedge HCLK);
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd;
        lows = 0;
        while (HREADYOUT !== 1'b1 && lows < 16) begin
            chk({tag, ".resp_w"}, 32'(HRESP), 32'(err));
            chk({tag, ".rdata_w"}, HRDATA, 32'h0);
            lows++;
            @(negedge HCLK);
        end
        chk({tag, ".waits"}, lows, err ? 1 : w);
        chk({tag, ".resp"}, 32'(HRESP), 32'(err));
        chk({tag, ".rdata"}, HRDATA, exp_rd);
    endtask

    task automatic nop_chk(input logic sel, input logic [1:0] trans, input string tag);
        HSEL = sel; HTRANS = trans; HWRITE = 1'b1; HADDR = 32'h10; HSIZE = 3'd2; HPROT = 4'b0011;
        @(posedge HCLK);
        @(negedge HCLK);
        HWDATA = 32'hFFFF_FFFF;
        HSEL = 1'b0; HTRANS = 2'b00;
        chk({tag, ".rdy"}, 32'(HREADYOUT), 32'd1);
        chk({tag, ".resp"}, 32'(HRESP), 32'd0);
        chk({tag, ".rdata"}, HRDATA, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'd2; HBURST = 3'd0; HPROT = 4'b0011; HWDATA = '0;
        repeat (3) @(negedge HCLK);
        chk("rst.rdy", 32'(HREADYOUT), 32'd1);
        chk("rst.resp", 32'(HRESP), 32'd0);
        chk("rst.rdata", HRDATA, 32'h0);
        HRESETn = 1'b1;

        for (int i = 0; i < 16; i++) xfer(1'b1, 32'(i * 4), 3'd2, $urandom, 4'b0011, "pre");
        xfer(1'b1, 32'h200, 3'd2, 32'hC0FF_EE00, 4'b0011, "pre128");
        idle(1);

        xfer(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 4'b0011, "wr10");
        idle(1);
        xfer(1'b0, 32'h10, 3'd2, 32'h0, 4'b0011, "rd10");
        idle(1);
        xfer(1'b1, 32'h13, 3'd0, 32'hAB00_0000, 4'b0011, "wrb13");
        xfer(1'b0, 32'h10, 3'd2, 32'h0, 4'b0011, "rd10b");
        chk("byte_merge", sb[4], 32'hABAD_BEEF);
        xfer(1'b1, 32'h14, 3'd1, 32'h0000_1234, 4'b0011, "wrh14");
        xfer(1'b0, 32'h14, 3'd2, 32'h0, 4'b0011, "rd14fwd");

        xfer(1'b0, 32'h02, 3'd2, 32'h0, 4'b0011, "err_mis");
        xfer(1'b1, 32'h400, 3'd2, 32'h1111_1111, 4'b0011, "err_oor");
        xfer(1'b1, 32'h12, 3'd2, 32'h2222_2222, 4'b0011, "err_wmis");
        xfer(1'b1, 32'h10, 3'd3, 32'h3333_3333, 4'b0011, "err_size");
        idle(1);
        chk("err_idle.resp", 32'(HRESP), 32'd0);
        chk("err_idle.rdy", 32'(HREADYOUT), 32'd1);
        xfer(1'b0, 32'h10, 3'd2, 32'h0, 4'b0011, "err_unch");
        idle(1);

        nop_chk(1'b1, 2'b01, "busy");
        nop_chk(1'b1, 2'b00, "idle");
        nop_chk(1'b0, 2'b10, "nosel");
        xfer(1'b0, 32'h10, 3'd2, 32'h0, 4'b0011, "nop_unch");
        idle(1);

        xfer(1'b1, 32'h200, 3'd2, 32'h1234_5678, 4'b0001, "prot_u");
        xfer(1'b1, 32'h200, 3'd2, 32'h8765_4321, 4'b0011, "prot_p");
        xfer(1'b0, 32'h200, 3'd2, 32'h0, 4'b0011, "prot_rd");
        idle(1);

        // Wait for a nonzero wait draw so reset lands inside WAIT
        n = 0;
        while ((int'(mdl_lfsr[3:0]) % (MAX_WAIT + 1)) == 0 && n < 64) begin
            @(negedge HCLK);
            n++;
        end
        HSEL = 1'b1; HADDR = 32'h20; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HPROT = 4'b0011;
        @(posedge HCLK);
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h5555_AAAA;
        chk("rstw.low", 32'(HREADYOUT), 32'd0);
        HRESETn = 1'b0;
        #1;
        chk("rstw.rdy", 32'(HREADYOUT), 32'd1);
        chk("rstw.resp", 32'(HRESP), 32'd0);
        chk("rstw.rdata", HRDATA, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        xfer(1'b0, 32'h20, 3'd2, 32'h0, 4'b0011, "rstw.old");
        idle(1);

        for (int i = 0; i < 200; i++) begin
            bit          wr;
            int          word, r, ofs;
            logic [2:0]  sz;
            wr   = 1'($urandom_range(0, 1));
            r    = $urandom_range(0, 99);
            word = $urandom_range(0, 7);
            if (r < 8) word = DEPTH + $urandom_range(0, 10);
            sz = 3'($urandom_range(0, 2));
            if (r >= 95) sz = 3'd3;
            if ($urandom_range(0, 4) == 0) ofs = $urandom_range(0, 3);
            else if (sz == 3'd0)           ofs = $urandom_range(0, 3);
            else if (sz == 3'd1)           ofs = 2 * $urandom_range(0, 1);
            else                           ofs = 0;
            xfer(wr, 32'(word * 4 + ofs), sz, $urandom, 4'($urandom), "rnd");
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ahb5_random_wait_subordinate.md
Name: ahb5_random_wait_subordinate

Overview:
AHB5 subordinate that answers the random transaction generator from the other end of the bus. It is a word-addressed SRAM model with LFSR-driven random wait states and protocol-correct two-cycle ERROR responses. It sits behind the interconnect as the memory target for initiator stress tests, and also serves as a reusable bus-functional responder.

Parameters:
MEM_DEPTH_WORDS, 256, number of 32-bit words; valid byte range 0 .. 4*MEM_DEPTH_WORDS-1
MAX_WAIT, 3, max wait states inserted per transfer (0 = always zero-wait)
LFSR_SEED, 16'hACE1, non-zero reset value of the wait-state LFSR

Ports:
HCLK  in  1  AHB clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  subordinate select
HADDR  in  32  address
HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HWRITE  in  1  1=write
HSIZE  in  3  transfer size
HBURST  in  3  burst type (ignored; each beat handled independently)
HPROT  in  4  protection
HWDATA  in  32  write data, data phase
HREADY  in  1  bus ready (from interconnect)
HREADYOUT  out  1  subordinate ready
HRESP  out  1  0=OKAY, 1=ERROR
HRDATA  out  32  read data

Behaviour:
- Clock/reset: HCLK; reset HRESETn, asynchronous, active-low.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, LFSR=LFSR_SEED. Memory is not reset.
- The 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) advances every cycle outside reset.
- Address phase accepted on a rising edge where HSEL=1, HREADY=1 and HTRANS[1]=1. The edge captures addr, write, size.
- IDLE, BUSY, or HSEL=0 with HREADY=1: no access. The next data phase is OKAY with zero waits.
- Error check at acceptance:
  - HSIZE>2, or
  - HSIZE=1 with addr[0]=1, or
  - HSIZE=2 with addr[1:0]!=0, or
  - addr[31:2] >= MEM_DEPTH_WORDS.
- FSM states: IDLE, WAIT, LAST, ERR1, ERR2.
- On acceptance, W = LFSR[3:0] % (MAX_WAIT+1), using the LFSR value at the accepting edge.
  - Error: go to ERR1.
  - W>0: go to WAIT with cnt=W.
  - W=0: go to LAST.
- WAIT: HREADYOUT=0, HRESP=0. cnt decrements each cycle; when cnt reaches 1, go to LAST. The transfer therefore sees exactly W low-HREADYOUT cycles.
- LAST: HREADYOUT=1, HRESP=0. The data phase completes in this cycle.
  - Read: HRDATA holds the full addressed word (no lane masking).
  - Write: HWDATA byte lanes selected by size/addr[1:0] (little-endian) are committed at the closing edge.
  - A new address phase may be accepted on the same edge (pipelined).
- ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1.
  - The failed transfer makes no memory update.
  - A transfer accepted at the ERR2 edge is processed normally; the initiator may cancel by driving IDLE.
- HRDATA is 0 in every cycle except a read's LAST cycle.
- Read-after-write forwarding: if a read is accepted on the edge that commits a write to the same word, the read returns the merged new data.
- Reset asserted mid-transfer: outputs immediately take reset values; a pending write is discarded.

Optional Feature:
AHB5_SUB_PROT_CHECK_EN
- Defined: an access with HPROT[1]=0 (unprivileged) to the upper half of memory (word index >= MEM_DEPTH_WORDS/2) takes the ERROR path, with no memory update.
- Undefined: HPROT is ignored entirely.

Test Plan:
- MAX_WAIT=0: write NONSEQ word 0x10 with 0xDEADBEEF, then read 0x10 -> each data phase HREADYOUT=1, HRESP=0; read HRDATA=0xDEADBEEF in the cycle after its address phase.
- Byte write HSIZE=0, addr 0x13, HWDATA=0xAB000000, then word read 0x10 -> HRDATA=0xABADBEEF. Pipelined zero-wait write then read of the same word -> forwarded 0xABADBEEF.
- Word read at addr 0x02, then word write at 0x400 (depth 256) -> each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (1,1); memory unchanged; a following IDLE returns HRESP=0.
- MAX_WAIT=3, 200 random transfers -> per-transfer low-HREADYOUT count is in 0..3 and matches the reference LFSR model seeded 0xACE1; all data read back matches the scoreboard.
- HTRANS=BUSY and IDLE with HSEL=1, plus NONSEQ with HSEL=0 -> zero-wait OKAY, HRDATA=0, no memory change.
- HRESETn pulsed low during WAIT of a write to 0x20 -> HREADYOUT=1, HRESP=0 immediately; a later read of 0x20 shows the old contents.
- AHB5_SUB_PROT_CHECK_EN defined, HPROT=4'b0001, write word 0x200 -> ERROR pair. Same write with HPROT=4'b0011 -> OKAY.
